and_gate_env_mealy: RTL and testbench
=====================================

AND_GATE_ENV_MEALY -- requirements
Module: and_gate_env_mealy

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports clk and reset.
REQ-002 Parameter ROUNDS, default 4 (range 1..255), SHALL set the number of full handshake rounds per run.
REQ-003 Parameter TIMEOUT, default 15 (range 1..255), SHALL set the maximum number of wait-state cycles allowed for an out_P/out_M event.
REQ-004 Parameter ALT, default 1, SHALL alternate the first-falling input per round when 1; when 0, a always falls first.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  level; begins a run when sampled high in IDLE
- out_P  in  1  one-cycle pulse; gate output rising event
- out_M  in  1  one-cycle pulse; gate output falling event
- a_P  out  1  one-cycle pulse; input a rising event
- a_M  out  1  one-cycle pulse; input a falling event
- b_P  out  1  one-cycle pulse; input b rising event
- b_M  out  1  one-cycle pulse; input b falling event
- busy  out  1  high in every state except IDLE, DONE and ERR
- done  out  1  one-cycle pulse at run completion
- err  out  1  sticky protocol/timeout error
- rounds_done  out  8  count of completed rounds in the current run

Function
REQ-006 All outputs SHALL be registered and decoded from state (Moore); a_P, a_M, b_P and b_M SHALL each be high for exactly one cycle per state visit.
REQ-007 States and transitions SHALL be:
- IDLE: start=1 -> A_UP.
- A_UP: a_P=1 -> B_UP.
- B_UP: b_P=1 -> W_OP.
- W_OP: out_P -> X_DN.
- X_DN: pulse the first-falling input's _M -> W_OM.
- W_OM: out_M -> Y_DN.
- Y_DN: pulse the other input's _M; increment rounds_done; go to DONE if rounds_done+1==ROUNDS, else A_UP.
- DONE: done=1 for one cycle -> IDLE.
- ERR: hold until reset, or until start=1, which clears err and goes to A_UP.
REQ-008 The first-falling input SHALL be a in even rounds and b in odd rounds when ALT=1 (round 0 = a); it SHALL always be a when ALT=0.
REQ-009 An 8-bit wait counter SHALL clear on entry to W_OP/W_OM and increment each cycle without an event; reaching TIMEOUT SHALL go to ERR with err=1.
REQ-010 In a wait state, an event arriving on the cycle the counter reaches TIMEOUT SHALL be accepted (no error).
REQ-011 out_P and out_M high in the same cycle SHALL go to ERR from any non-IDLE state.
REQ-012 In W_OP, out_M SHALL go to ERR; in W_OM, out_P SHALL go to ERR.
REQ-013 start SHALL be ignored while busy=1; start held high through DONE SHALL begin a new run from IDLE on the next cycle.
REQ-014 rounds_done SHALL clear on each run start (IDLE->A_UP or ERR->A_UP) and saturate at ROUNDS.
REQ-015 Latency from start sampled to a_P high SHALL be 1 cycle; from out_P sampled to the first _M pulse it SHALL be 1 cycle.

Reset
REQ-016 reset SHALL asynchronously force state IDLE and clear wait counter, rounds_done, err, done, busy, and all _P/_M outputs to 0.
REQ-017 reset asserted mid-run SHALL abandon the run with no further pulses; the run SHALL restart only on a new start after reset deasserts.

Configuration
REQ-018 Macro AND_ENV_SPURIOUS_CHECK_EN SHALL control the spurious-event check.
- Defined: out_P or out_M in A_UP, B_UP, X_DN or Y_DN SHALL go to ERR.
- Undefined: those events SHALL be ignored; REQ-011 and REQ-012 still apply.

Verification
REQ-019 ROUNDS=2, ALT=1, ideal gate model replying 2 cycles after each input-completing event -> pulse order a_P,b_P,a_M,b_M,a_P,b_P,b_M,a_M; done at end; rounds_done=2; err=0.
REQ-020 TIMEOUT=15, out_P never sent -> ERR entered 15 cycles after entering W_OP; err=1; busy=0; no further pulses until start.
REQ-021 out_P and out_M pulsed together in W_OP -> err=1 next cycle.
REQ-022 With AND_ENV_SPURIOUS_CHECK_EN defined, out_P in B_UP -> err=1; with the macro undefined -> event ignored and run completes.
REQ-023 reset asserted during W_OM of round 1 -> all outputs 0 immediately; start afterwards -> rounds_done restarts at 0.
REQ-024 Event arriving on the cycle the counter reaches TIMEOUT -> accepted; err=0.

Source files
------------

// File: rtl/and_gate_env_mealy.sv
// Stimulus environment that walks an AND gate through rise/fall handshake rounds and
// watches its output events. Optional macro AND_ENV_SPURIOUS_CHECK_EN flags stray events.
module and_gate_env_mealy #(
    parameter int ROUNDS  = 4,
    parameter int TIMEOUT = 15,
    parameter int ALT     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       out_P,
    input  logic       out_M,
    output logic       a_P,
    output logic       a_M,
    output logic       b_P,
    output logic       b_M,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rounds_done
);

    // state | meaning
    // IDLE  | waiting for start
    // A_UP  | pulse a_P
    // B_UP  | pulse b_P
    // W_OP  | wait for gate rising event (out_P)
    // X_DN  | pulse first-falling input's _M
    // W_OM  | wait for gate falling event (out_M)
    // Y_DN  | pulse the other input's _M, round complete
    // DONE  | one-cycle done pulse
    // ERR   | protocol/timeout error, held until start or reset
    typedef enum logic [3:0] {
        S_IDLE, S_A_UP, S_B_UP, S_W_OP, S_X_DN, S_W_OM, S_Y_DN, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] ROUNDS_L  = 8'(ROUNDS);
    localparam logic [7:0] TO_LAST_L = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic [7:0] r_rounds;
    logic       r_a_p, r_a_m, r_b_p, r_b_m;
    logic       r_busy, r_done, r_err;

    logic       w_both;
    logic       w_spur;
    logic       w_to;
    logic       w_first_b;
    logic       w_run_start;
    state_t     w_next;

    assign w_both = out_P & out_M;
`ifdef AND_ENV_SPURIOUS_CHECK_EN
    assign w_spur = out_P | out_M;
`else
    assign w_spur = 1'b0;
`endif
    // Counter holds the number of event-less cycles already spent in this wait state.
    assign w_to      = (r_wait == TO_LAST_L);
    assign w_first_b = (ALT != 0) && r_rounds[0];

    function automatic state_t f_next(
        input state_t     st,
        input logic       i_start,
        input logic       i_op,
        input logic       i_om,
        input logic       i_both,
        input logic       i_spur,
        input logic       i_to,
        input logic [7:0] i_rounds
    );
        state_t n;
        n = st;
        case (st)
            S_IDLE: n = i_start ? S_A_UP : S_IDLE;
            S_A_UP: n = (i_both || i_spur) ? S_ERR : S_B_UP;
            S_B_UP: n = (i_both || i_spur) ? S_ERR : S_W_OP;
            S_W_OP: begin
                if (i_both || i_om)  n = S_ERR;
                else if (i_op)       n = S_X_DN;
                else if (i_to)       n = S_ERR;
                else                 n = S_W_OP;
            end
            S_X_DN: n = (i_both || i_spur) ? S_ERR : S_W_OM;
            S_W_OM: begin
                if (i_both || i_op)  n = S_ERR;
                else if (i_om)       n = S_Y_DN;
                else if (i_to)       n = S_ERR;
                else                 n = S_W_OM;
            end
            // rounds_done was already bumped on entry to Y_DN
            S_Y_DN: begin
                if (i_both || i_spur)          n = S_ERR;
                else if (i_rounds == ROUNDS_L) n = S_DONE;
                else                           n = S_A_UP;
            end
            S_DONE: n = i_both ? S_ERR : S_IDLE;
            S_ERR: begin
                if (i_both)       n = S_ERR;
                else if (i_start) n = S_A_UP;
                else              n = S_ERR;
            end
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    assign w_next = f_next(r_state, start, out_P, out_M, w_both, w_spur, w_to, r_rounds);
    assign w_run_start = (w_next == S_A_UP) && ((r_state == S_IDLE) || (r_state == S_ERR));

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wait   <= 8'd0;
            r_rounds <= 8'd0;
            r_a_p    <= 1'b0;
            r_a_m    <= 1'b0;
            r_b_p    <= 1'b0;
            r_b_m    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;

            if (((r_state == S_W_OP) || (r_state == S_W_OM)) && (w_next == r_state))
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;

            if (w_run_start)
                r_rounds <= 8'd0;
            else if ((w_next == S_Y_DN) && (r_rounds != ROUNDS_L))
                r_rounds <= r_rounds + 8'd1;

            r_a_p  <= (w_next == S_A_UP);
            r_b_p  <= (w_next == S_B_UP);
            r_a_m  <= ((w_next == S_X_DN) && !w_first_b) || ((w_next == S_Y_DN) && w_first_b);
            r_b_m  <= ((w_next == S_X_DN) && w_first_b)  || ((w_next == S_Y_DN) && !w_first_b);
            r_busy <= (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERR);
            r_done <= (w_next == S_DONE);
            r_err  <= (w_next == S_ERR);
        end
    end

    assign a_P         = r_a_p;
    assign a_M         = r_a_m;
    assign b_P         = r_b_p;
    assign b_M         = r_b_m;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign rounds_done = r_rounds;

endmodule

// File: tb/tb_and_gate_env_mealy.sv
// Bench for and_gate_env_mealy: two parameterisations driven by one stimulus stream,
// each compared every cycle against a round/step sequence model, plus directed scenarios.
module tb_and_gate_env_mealy;

    localparam int R0 = 2, T0 = 15, A0 = 1;
    localparam int R1 = 3, T1 = 4,  A1 = 0;
`ifdef AND_ENV_SPURIOUS_CHECK_EN
    localparam bit SPUR = 1'b1;
`else
    localparam bit SPUR = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

    typedef struct packed {
        int mode;
        int step;       // 0 rise a, 1 rise b, 2 wait up, 3 first fall, 4 wait down, 5 second fall
        int completed;
        int waited;
    } mdl_t;

    logic clk = 1'b0;
    logic reset, start, out_P, out_M;
    logic [1:0] o_aP, o_aM, o_bP, o_bM, o_busy, o_done, o_err;
    logic [7:0] o_rnd [2];

    mdl_t m [2];
    int   n_pass = 0;
    int   n_total = 0;
    bit   auto_gate;
    int   gate_tgt;
    logic s_aP, s_aM, s_bP, s_bM, s_busy, s_done, s_err;
    int   s_rnd;

    always #5 clk = ~clk;

    and_gate_env_mealy #(.ROUNDS(R0), .TIMEOUT(T0), .ALT(A0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .out_P(out_P), .out_M(out_M),
        .a_P(o_aP[0]), .a_M(o_aM[0]), .b_P(o_bP[0]), .b_M(o_bM[0]),
        .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .rounds_done(o_rnd[0])
    );

    and_gate_env_mealy #(.ROUNDS(R1), .TIMEOUT(T1), .ALT(A1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .out_P(out_P), .out_M(out_M),
        .a_P(o_aP[1]), .a_M(o_aM[1]), .b_P(o_bP[1]), .b_M(o_bM[1]),
        .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .rounds_done(o_rnd[1])
    );

    function automatic mdl_t mstep(input mdl_t c, input int rnds, input int tmo,
                                   input logic st, input logic op, input logic om);
        mdl_t n;
        logic want, wrong;
        n = c;
        if (c.mode == M_IDLE) begin
            if (st) begin n.mode = M_RUN; n.step = 0; n.completed = 0; end
        end else if (c.mode == M_DONE) begin
            n.mode = (op && om) ? M_ERR : M_IDLE;
        end else if (c.mode == M_ERR) begin
            if (!(op && om) && st) begin n.mode = M_RUN; n.step = 0; n.completed = 0; end
        end else if (op && om) begin
            n.mode = M_ERR;
        end else if (c.step == 2 || c.step == 4) begin
            want  = (c.step == 2) ? op : om;
            wrong = (c.step == 2) ? om : op;
            if (wrong) n.mode = M_ERR;
            else if (want) begin
                n.step = c.step + 1;
                if (c.step == 4 && c.completed < rnds) n.completed = c.completed + 1;
            end else begin
                n.waited = c.waited + 1;
                if (n.waited >= tmo) n.mode = M_ERR;
            end
        end else if (SPUR && (op || om)) begin
            n.mode = M_ERR;
        end else if (c.step == 5) begin
            if (c.completed == rnds) n.mode = M_DONE;
            else n.step = 0;
        end else begin
            n.step = c.step + 1;
            if (n.step == 2 || n.step == 4) n.waited = 0;
        end
        return n;
    endfunction

    function automatic logic [14:0] mexp(input mdl_t c, input int alt);
        logic run, fb, ap, am, bp, bm, f1, f2;
        int   ridx;
        run  = (c.mode == M_RUN);
        ridx = (c.step == 5) ? c.completed - 1 : c.completed;
        fb   = (alt != 0) && (ridx % 2 == 1);
        f1   = run && c.step == 3;
        f2   = run && c.step == 5;
        ap   = run && c.step == 0;
        bp   = run && c.step == 1;
        am   = (f1 && !fb) || (f2 && fb);
        bm   = (f1 && fb) || (f2 && !fb);
        return {ap, am, bp, bm, run, c.mode == M_DONE, c.mode == M_ERR, 8'(c.completed)};
    endfunction

    function automatic logic [14:0] dvec(input int k);
        return {o_aP[k], o_aM[k], o_bP[k], o_bM[k], o_busy[k], o_done[k], o_err[k], o_rnd[k]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= mstep(m[0], R0, T0, start, out_P, out_M);
            m[1] <= mstep(m[1], R1, T1, start, out_P, out_M);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // One cycle: sample and compare at the falling edge, then set inputs for the next rising edge.
    task automatic cyc(input logic st, input logic fp, input logic fm);
        logic       op, om;
        logic [14:0] e;
        @(negedge clk);
        s_aP = o_aP[0]; s_aM = o_aM[0]; s_bP = o_bP[0]; s_bM = o_bM[0];
        s_busy = o_busy[0]; s_done = o_done[0]; s_err = o_err[0]; s_rnd = int'(o_rnd[0]);
        for (int k = 0; k < 2; k++) begin
            e = mexp(m[k], (k == 0) ? A0 : A1);
            n_total++;
            if (dvec(k) === e) n_pass++;
            else $display("FAIL model dut%0d at %0t: got %h expected %h", k, $time, dvec(k), e);
        end
        op = fp;
        om = fm;
        if (auto_gate && m[0].mode == M_RUN) begin
            if (m[0].step == 2 && m[0].waited == gate_tgt) op = 1'b1;
            if (m[0].step == 4 && m[0].waited == gate_tgt) om = 1'b1;
        end
        start = st;
        out_P = op;
        out_M = om;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        int exp_ord[8];
        int cnt, nb;
        logic st, fp, fm;
        exp_ord = '{1, 2, 3, 4, 1, 2, 4, 3};
        reset = 1'b1; start = 0; out_P = 0; out_M = 0; auto_gate = 0; gate_tgt = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0);
        chk("reset busy", s_busy, 0);
        chk("reset err", s_err, 0);
        chk("reset rounds_done", s_rnd, 0);

        // Two-round run with an ideal gate, start held high throughout.
        auto_gate = 1; gate_tgt = 1;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("start to a_P latency", s_aP, 1);
        for (int i = 0; i < 80; i++) begin
            if (s_aP) q.push_back(1);
            if (s_bP) q.push_back(2);
            if (s_aM) q.push_back(3);
            if (s_bM) q.push_back(4);
            if (s_done) break;
            cyc(1, 0, 0);
        end
        chk("run done", s_done, 1);
        chk("run rounds_done", s_rnd, 2);
        chk("run err", s_err, 0);
        chk("pulse count", q.size(), 8);
        for (int k = 0; k < 8 && k < q.size(); k++) chk($sformatf("pulse order %0d", k), q[k], exp_ord[k]);
        cyc(1, 0, 0);
        chk("idle after done", s_busy, 0);
        cyc(0, 0, 0);
        chk("restart from held start", s_aP, 1);
        chk("restart rounds_done", s_rnd, 0);

        // Timeout: gate never answers.
        do_reset();
        auto_gate = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 10 && !s_bP; i++) cyc(0, 0, 0);
        chk("saw b_P", s_bP, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0);
            if (s_err) break;
            cnt++;
        end
        chk("timeout cycles", cnt, 15);
        chk("timeout err", s_err, 1);
        chk("timeout busy", s_busy, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            chk("err quiet", {s_aP, s_aM, s_bP, s_bM}, 0);
        end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("err cleared by start", s_err, 0);
        chk("err restart a_P", s_aP, 1);

        // Gate answers on the last permitted wait cycle.
        auto_gate = 1; gate_tgt = T0 - 1;
        for (int i = 0; i < 200; i++) begin
            if (s_done || s_err) break;
            cyc(0, 0, 0);
        end
        chk("late event done", s_done, 1);
        chk("late event err", s_err, 0);

        // Both gate events together in W_OP.
        do_reset();
        auto_gate = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 10 && !s_bP; i++) cyc(0, 0, 0);
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        chk("both events err", s_err, 1);

        // Stray out_P during B_UP.
        do_reset();
        auto_gate = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 10 && !s_aP; i++) cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("spurious err", s_err, SPUR ? 1 : 0);
        if (!SPUR) begin
            auto_gate = 1; gate_tgt = 1;
            for (int i = 0; i < 80; i++) begin
                if (s_done || s_err) break;
                cyc(0, 0, 0);
            end
            chk("spurious ignored done", s_done, 1);
        end

        // Reset during W_OM of round 1.
        do_reset();
        auto_gate = 1; gate_tgt = 1;
        cyc(1, 0, 0);
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0);
            if (s_bP) nb++;
            if (nb == 2 && (s_aM || s_bM)) break;
        end
        cyc(0, 0, 0);
        chk("in W_OM round 1", s_rnd, 1);
        #2 reset = 1'b1;
        #1 chk("async reset outputs", int'(dvec(0)), 0);
        cyc(0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0);
        chk("after reset quiet", int'(dvec(0)), 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("post reset a_P", s_aP, 1);
        chk("post reset rounds_done", s_rnd, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (m[0].mode != M_RUN || (m[0].step != 2 && m[0].step != 4)) begin
                cnt = $urandom_range(0, 15);
                if (cnt < 10)      gate_tgt = cnt % 4;
                else if (cnt < 13) gate_tgt = T0 - 1;
                else if (cnt == 13) gate_tgt = T1 - 1;
                else               gate_tgt = 255;
            end
            st = ($urandom_range(0, 2) == 0);
            fp = ($urandom_range(0, 79) == 0);
            fm = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                cyc(st, 0, 0);
                reset = 1'b0;
            end else begin
                cyc(st, fp, fm);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
